// File: rtl/step_pkg.sv
// step_pkg: state encoding, default minimum divisor and divisor-to-phase helper for step_pulse_sequencer
package step_pkg;
    localparam int MIN_DIV_DEF = 2;
    localparam int PKG_DIV_W   = 32;

    typedef enum logic [2:0] {S_IDLE, S_SETUP, S_HIGH, S_LOW, S_DONE} state_t;

    typedef struct packed {
        logic [PKG_DIV_W-1:0] h;
        logic [PKG_DIV_W-1:0] l;
    } phase_t;

    // Clamp to min_div, split into high = d/2 (never 0) and low = remainder.
    function automatic phase_t calc_phase(input logic [PKG_DIV_W-1:0] div,
                                          input logic [PKG_DIV_W-1:0] min_div);
        logic [PKG_DIV_W-1:0] d;
        phase_t p;
        d   = (div < min_div) ? min_div : div;
        p.h = ((d >> 1) == '0) ? PKG_DIV_W'(1) : (d >> 1);
        p.l = d - p.h;
        return p;
    endfunction
endpackage

// File: rtl/step_phase_timer.sv
// step_phase_timer: loadable down-counter; tc flags the last cycle of a loaded phase
module step_phase_timer
    import step_pkg::*;
#(
    parameter int W = PKG_DIV_W
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         load,
    input  logic [W-1:0] load_val,
    output logic         tc
);
    logic [W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = load ? load_val : ((cnt_q != '0) ? cnt_q - 1'b1 : cnt_q);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) cnt_q <= '0;
        else       cnt_q <= cnt_d;
    end

    assign tc = (cnt_q == W'(1));
endmodule

// File: rtl/step_pulse_sequencer.sv
// step_pulse_sequencer: burst step-pulse generator with glitch-free divisor retune on period boundaries.
// Define STEP_PULSE_DIR_EN to add dir_in/dir_out and a one-period direction setup phase.
module step_pulse_sequencer
    import step_pkg::*;
#(
    parameter int DIV_W   = 32,
    parameter int CNT_W   = 16,
    parameter int MIN_DIV = MIN_DIV_DEF
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [DIV_W-1:0] div_value,
    input  logic [CNT_W-1:0] step_count,
    input  logic             start,
    input  logic             abort,
    output logic             busy,
    output logic             done,
    output logic             step_out,
    output logic [CNT_W-1:0] steps_done
`ifdef STEP_PULSE_DIR_EN
    ,
    input  logic             dir_in,
    output logic             dir_out
`endif
);
    localparam phase_t MIN_PHASE = calc_phase(PKG_DIV_W'(MIN_DIV), PKG_DIV_W'(MIN_DIV));

    state_t               state_q, state_d;
    logic                 busy_q, busy_d, done_q, done_d, step_q, step_d;
    logic [CNT_W-1:0]     steps_done_q, steps_done_d, count_q, count_d;
    phase_t               shadow_q, shadow_d, ph_in;
    logic                 load, tc, finish;
    logic [PKG_DIV_W-1:0] load_val;
`ifdef STEP_PULSE_DIR_EN
    logic                 dir_q, dir_d;
`endif

    assign ph_in = calc_phase(PKG_DIV_W'(div_value), PKG_DIV_W'(MIN_DIV));

    step_phase_timer #(.W(PKG_DIV_W)) u_timer (
        .clk      (clk),
        .reset    (reset),
        .load     (load),
        .load_val (load_val),
        .tc       (tc)
    );

    always_comb begin
        state_d      = state_q;
        busy_d       = busy_q;
        done_d       = 1'b0;
        step_d       = step_q;
        steps_done_d = steps_done_q;
        count_d      = count_q;
        shadow_d     = shadow_q;
        load         = 1'b0;
        load_val     = shadow_q.l;
        finish       = 1'b0;
`ifdef STEP_PULSE_DIR_EN
        dir_d        = dir_q;
`endif
        case (state_q)
            S_IDLE: if (start && !abort) begin
                shadow_d     = ph_in;
                steps_done_d = '0;
                count_d      = step_count;
`ifdef STEP_PULSE_DIR_EN
                dir_d        = dir_in;
`endif
                if (step_count == '0) begin
                    state_d = S_DONE;
                    done_d  = 1'b1;
                end else begin
                    busy_d = 1'b1;
                    load   = 1'b1;
`ifdef STEP_PULSE_DIR_EN
                    state_d  = S_SETUP;
                    load_val = ph_in.h + ph_in.l;
`else
                    state_d  = S_HIGH;
                    step_d   = 1'b1;
                    load_val = ph_in.h;
`endif
                end
            end
            S_SETUP: if (abort) finish = 1'b1;
            else if (tc) begin
                state_d  = S_HIGH;
                step_d   = 1'b1;
                load     = 1'b1;
                load_val = shadow_q.h;
            end
            S_HIGH: if (abort) finish = 1'b1;
            else if (tc) begin
                state_d      = S_LOW;
                step_d       = 1'b0;
                load         = 1'b1;
                load_val     = shadow_q.l;
                steps_done_d = (steps_done_q == count_q) ? steps_done_q : steps_done_q + 1'b1;
            end
            // Last LOW cycle is the period boundary: resample the divisor here only.
            S_LOW: if (abort || (tc && steps_done_q == count_q)) finish = 1'b1;
            else if (tc) begin
                state_d  = S_HIGH;
                step_d   = 1'b1;
                shadow_d = ph_in;
                load     = 1'b1;
                load_val = ph_in.h;
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
        if (finish) begin
            state_d = S_DONE;
            done_d  = 1'b1;
            busy_d  = 1'b0;
            step_d  = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= S_IDLE;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            step_q       <= 1'b0;
            steps_done_q <= '0;
            count_q      <= '0;
            shadow_q     <= MIN_PHASE;
`ifdef STEP_PULSE_DIR_EN
            dir_q        <= 1'b0;
`endif
        end else begin
            state_q      <= state_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            step_q       <= step_d;
            steps_done_q <= steps_done_d;
            count_q      <= count_d;
            shadow_q     <= shadow_d;
`ifdef STEP_PULSE_DIR_EN
            dir_q        <= dir_d;
`endif
        end
    end

    assign busy       = busy_q;
    assign done       = done_q;
    assign step_out   = step_q;
    assign steps_done = steps_done_q;
`ifdef STEP_PULSE_DIR_EN
    assign dir_out    = dir_q;
`endif
endmodule

// File: tb/tb_step_pulse_sequencer.sv
// tb_step_pulse_sequencer: directed and randomized bursts checked against a pulse-timeline model
module tb_step_pulse_sequencer;
    localparam int MAXC = 1024;

    logic        clk = 1'b0;
    logic        reset, start, abort;
    logic [31:0] div_value;
    logic [15:0] step_count;
    logic        busy, done, step_out;
    logic [15:0] steps_done;
`ifdef STEP_PULSE_DIR_EN
    logic        dir_in = 1'b0;
    logic        dir_out;
`endif

    int tests = 0;
    int fails = 0;
    int div_at[MAXC];

    step_pulse_sequencer dut (
        .clk        (clk),
        .reset      (reset),
        .div_value  (div_value),
        .step_count (step_count),
        .start      (start),
        .abort      (abort),
        .busy       (busy),
        .done       (done),
        .step_out   (step_out),
        .steps_done (steps_done)
`ifdef STEP_PULSE_DIR_EN
        ,
        .dir_in     (dir_in),
        .dir_out    (dir_out)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input int c, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s cyc=%0d observed=%0h expected=%0h", tag, c, obs, exp);
        end
    endtask

    task automatic fill_const(input int v);
        for (int c = 0; c < MAXC; c++) div_at[c] = v;
    endtask

    task automatic fill_rand();
        int v = $urandom_range(0, 12);
        for (int c = 0; c < MAXC; c++) begin
            if ($urandom_range(0, 9) == 0) v = $urandom_range(0, 12);
            div_at[c] = v;
        end
    endtask

    // Pulse k starts at t[k] with period D = clamp(div one cycle before t[k]);
    // it is high for max(D/2,1) cycles and counts once its high phase has ended.
    // a = -1: no abort; a = -2: abort at a random cycle up to and including the done cycle.
    task automatic run_burst(input int n, input int a);
        int t[$];
        int h[$];
        int tt = 1;
        int d, dc, cc, es, esd;
        bit ab;
        for (int k = 0; k < n && tt < MAXC; k++) begin
            d = (div_at[tt-1] < 2) ? 2 : div_at[tt-1];
            t.push_back(tt);
            h.push_back(d / 2);
            tt += d;
        end
        dc = (n == 0) ? 1 : tt;
        if (a == -2) a = $urandom_range(1, dc);
        ab = (a >= 1) && (a < dc);
        if (ab) dc = a + 1;
        for (int c = 0; c <= dc + 1; c++) begin
            @(posedge clk);
            #1;
            div_value  = div_at[c];
            start      = (c == 0) || (c <= dc && $urandom_range(0, 7) == 0);
            step_count = (c == 0) ? 16'(n) : 16'($urandom);
            abort      = (c == a);
            @(negedge clk);
            if (c >= 1) begin
                cc  = (ab && c > a) ? a : c;
                es  = 0;
                esd = 0;
                foreach (t[k]) begin
                    if (t[k] <= cc && cc < t[k] + h[k]) es = 1;
                    if (t[k] + h[k] <= cc) esd++;
                end
                if (ab && c > a) es = 0;
                check("step_out", c, 32'(step_out), 32'(es));
                check("steps_done", c, 32'(steps_done), 32'(esd));
                check("busy", c, 32'(busy), 32'(c < dc));
                check("done", c, 32'(done), 32'(c == dc));
            end
        end
        start = 1'b0;
        abort = 1'b0;
    endtask

    initial begin
        reset      = 1'b1;
        start      = 1'b0;
        abort      = 1'b0;
        div_value  = 32'd10;
        step_count = 16'd0;
        #12;
        check("rst_step", 0, 32'(step_out), 0);
        check("rst_busy", 0, 32'(busy), 0);
        check("rst_done", 0, 32'(done), 0);
        check("rst_steps_done", 0, 32'(steps_done), 0);
        @(negedge clk);
        reset = 1'b0;

        fill_const(10); run_burst(3, -1);
        fill_const(7);  run_burst(1, -1);
        fill_const(0);  run_burst(1, -1);
        fill_const(1);  run_burst(2, -1);
        for (int c = 0; c < MAXC; c++) div_at[c] = (c < 10) ? 8 : 20;
        run_burst(4, -1);
        fill_const(6);  run_burst(100, 26);
        fill_const(5);  run_burst(0, -1);

        @(posedge clk);
        #1;
        start = 1'b1; abort = 1'b1; step_count = 16'd3; div_value = 32'd4;
        @(posedge clk);
        #1;
        start = 1'b0; abort = 1'b0;
        for (int c = 1; c <= 3; c++) begin
            @(negedge clk);
            check("abort_start_busy", c, 32'(busy), 0);
            check("abort_start_done", c, 32'(done), 0);
            check("abort_start_step", c, 32'(step_out), 0);
            @(posedge clk);
        end

        @(posedge clk);
        #1;
        div_value = 32'd10; step_count = 16'd3; start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (6) @(posedge clk);
        @(negedge clk);
        check("midlow_busy", 7, 32'(busy), 1);
        check("midlow_steps_done", 7, 32'(steps_done), 1);
        #2 reset = 1'b1;
        #1;
        check("async_rst_step", 7, 32'(step_out), 0);
        check("async_rst_busy", 7, 32'(busy), 0);
        check("async_rst_done", 7, 32'(done), 0);
        check("async_rst_steps_done", 7, 32'(steps_done), 0);
        @(negedge clk);
        reset = 1'b0;

        for (int i = 0; i < 25; i++) begin
            fill_rand();
            run_burst($urandom_range(0, 5), ($urandom_range(0, 2) == 0) ? -2 : -1);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/step_pulse_sequencer.md
Name: step_pulse_sequencer

Overview:
- Consumes the 32-bit clock-divide word driven by the clock-frequency-divider PIO register.
- Generates a burst of step pulses for one dispenser axis, with a programmable pulse count and a start/busy/done handshake.
- Divisor changes take effect only on period boundaries, so a CPU write never produces a runt or stretched pulse.
- Sits between the HPS-written PIO registers and the motor-driver step pin.

Parameters:
- DIV_W, 32, width of divisor input (matches PIO out_port).
- CNT_W, 16, width of pulse-count request and progress counter.
- MIN_DIV, 2, smallest legal period in clk cycles; smaller divisors are clamped to this.

Ports:
- clk  in  1  system clock; single clock domain.
- reset  in  1  asynchronous, active-high reset.
- div_value  in  DIV_W  period in clk cycles, from the PIO out_port.
- step_count  in  CNT_W  number of pulses for the burst; sampled at start.
- start  in  1  single-cycle request; accepted only in IDLE.
- abort  in  1  terminates the burst.
- busy  out  1  high from the cycle after accepted start until the DONE cycle.
- done  out  1  one-cycle pulse when a burst completes or is aborted.
- step_out  out  1  registered step pulse to the driver.
- steps_done  out  CNT_W  count of completed pulses in the current/last burst.

Behaviour:
- Reset (async, reset=1) values: state IDLE, busy=0, done=0, step_out=0, steps_done=0, shadow divisor=MIN_DIV.
- Effective divisor D = max(div_value, MIN_DIV). Phase lengths: H = D>>1 (at least 1), L = D-H. All arithmetic is unsigned DIV_W.
- The shadow divisor is sampled from div_value in exactly two places:
  - when start is accepted;
  - on the last cycle of every LOW phase.
- States IDLE, HIGH, LOW, DONE:
  - IDLE: start=1 with step_count!=0 → HIGH next cycle. Latch step_count, clear steps_done, load phase counter with H, busy=1.
  - IDLE: start=1 with step_count==0 → DONE next cycle, with no pulse.
  - HIGH: step_out=1 for exactly H cycles. Then go to LOW and load L.
  - LOW: step_out=0 for exactly L cycles. steps_done increments on the first LOW cycle.
  - At the end of LOW: if steps_done==latched count → DONE; else → HIGH with the newly sampled shadow divisor.
  - DONE: done=1 and busy=0 for one cycle, then IDLE.
- Latency: step_out rises on the first clk edge after the start cycle.
- Pulse period is exactly D cycles. A burst of N pulses spans N*D cycles, followed by one DONE cycle.
- start while not IDLE: ignored; no queuing. step_count changes after acceptance have no effect.
- abort in HIGH or LOW: step_out=0 on the next edge, go to DONE; steps_done holds its current value. A HIGH phase truncated by abort is not counted.
- abort in IDLE or DONE: no effect. abort together with start in IDLE: abort wins, start is dropped, no done pulse.
- steps_done saturates at the latched count; it cannot wrap.
- div_value is allowed to change in any cycle; glitch-free behaviour is guaranteed by the period-boundary sampling.

Optional Feature:
- Macro STEP_PULSE_DIR_EN.
- When defined:
  - Adds ports dir_in (in, 1) and dir_out (out, 1; reset 0).
  - dir_in is latched into dir_out when start is accepted.
  - Adds a SETUP state of D cycles (step_out=0) between IDLE and the first HIGH, for driver direction setup time.
  - abort in SETUP → DONE.
- When undefined: no dir ports, no SETUP state; timing is exactly as above.

Decomposition:
- Shared package step_pkg holds:
  - the state enum typedef (IDLE, SETUP, HIGH, LOW, DONE);
  - localparam MIN_DIV default;
  - a function computing clamped H and L from a divisor.
- One natural sub-module: step_phase_timer. It is a loadable down-counter with a terminal-count flag, instantiated once.

Test Plan:
- Basic burst: div_value=10, step_count=3, start → 3 pulses, each 5 high / 5 low. done asserts at cycle 31 after start; steps_done=3; busy high cycles 1–30.
- Odd divisor with clamp:
  - div_value=7, count=1 → high 3, low 4.
  - div_value=0 or 1 → high 1, low 1 (MIN_DIV).
- Mid-burst retune: div_value=8, count=4; write 20 during the second HIGH → pulse 2 unchanged at 8, pulses 3–4 at 20; no runt pulse.
- Abort: count=100, div=6, abort during the 5th HIGH → step_out low next cycle, done pulse, steps_done=4, busy=0.
- Edge cases:
  - step_count=0 → done the cycle after start, step_out never rises.
  - start during busy → ignored.
  - async reset mid-LOW → all outputs 0 immediately.
- With STEP_PULSE_DIR_EN: dir_in=1, div=4, count=2 → dir_out=1 at acceptance, 4 low SETUP cycles, then 2 pulses.
